// File: rtl/adder_chunk_seq_if.sv
// Valid/ready operand and result channels of the chunked multi-precision add sequencer.
// The master side feeds operands and consumes results; the slave side is the sequencer.
interface adder_chunk_seq_if #(
  parameter int W      = 22,
  parameter int NCHUNK = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [W*NCHUNK-1:0]   in_a;
  logic [W*NCHUNK-1:0]   in_b;
  logic                  in_cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [W*NCHUNK-1:0]   out_sum;
  logic                  out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/adder_chunk_seq.sv
// Multi-precision add sequencer: streams NCHUNK 22-bit chunks, LSB first, through one
// parallel-prefix adder core, rippling the carry between chunks through a register.

// 22-bit Knowles-family parallel-prefix adder (minimum-depth, fan-out-1 prefix tree).
module adder #(
  parameter int W = 22
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int LEVELS = $clog2(W);

  logic [W-1:0] g0, p0, g, p, g_n, p_n;
  logic [W:0]   c;

  // NOTE: every variable gets a value before any branch or loop, so no path can infer a latch.
  always_comb begin
    g0  = a & b;
    p0  = a ^ b;
    g   = g0;
    p   = p0;
    g_n = g0;
    p_n = p0;
    for (int l = 0; l < LEVELS; l++) begin
      g_n = g;
      p_n = p;
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << l)) begin
          g_n[i] = g[i] | (p[i] & g[i-(1<<l)]);
          p_n[i] = p[i] & p[i-(1<<l)];
        end
      end
      g = g_n;
      p = p_n;
    end
    // Group generate/propagate over [i:0] with cin folded in as a generate at bit -1.
    c    = {g | (p & {W{cin}}), cin};
    sum  = p0 ^ c[W-1:0];
    cout = c[W];
  end
endmodule

module adder_chunk_seq #(
  parameter int W      = 22,
  parameter int NCHUNK = 4,
  parameter int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_chunk_seq_if.slave bus,
  output logic             busy
);
  localparam int            DW   = W * NCHUNK;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx;
  logic          carry;
  logic [DW-1:0] a_q, b_q;
  logic [W-1:0]  core_a, core_b, core_sum;
  logic          core_cout;
  logic          accept, last;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (idx == LAST);
  assign core_a = a_q[idx*W +: W];
  assign core_b = b_q[idx*W +: W];

  adder #(.W(W)) u_core (
    .a   (core_a),
    .b   (core_b),
    .cin (carry),
    .sum (core_sum),
    .cout(core_cout)
  );

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) state_n = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: the wide operand and result registers are reset too, so an aborted run leaves no stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx          <= '0;
      carry        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      bus.out_sum  <= '0;
      bus.out_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q   <= bus.in_a;
          b_q   <= bus.in_b;
          carry <= bus.in_cin;
          idx   <= '0;
        end
        RUN: begin
          bus.out_sum[idx*W +: W] <= core_sum;
          carry                   <= core_cout;
          if (last) begin
            bus.out_cout <= core_cout;
            idx          <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_chunk_seq.sv
// Scoreboard bench for adder_chunk_seq: directed carry cases, backpressure, mid-run reset,
// random traffic with random out_ready, and a single-chunk instance.
module tb_adder_chunk_seq;
  localparam int W  = 22;
  localparam int N  = 4;
  localparam int DW = W * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, busy1;
  always #5 clk = ~clk;

  adder_chunk_seq_if #(.W(W), .NCHUNK(N)) bus ();
  adder_chunk_seq_if #(.W(W), .NCHUNK(1)) bus1 ();

  adder_chunk_seq #(.W(W), .NCHUNK(N), .IW(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );
  adder_chunk_seq #(.W(W), .NCHUNK(1), .IW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1)
  );

  typedef struct packed { logic [DW-1:0] sum; logic cout; } exp_t;
  typedef struct packed { logic [W-1:0]  sum; logic cout; } exp1_t;

  exp_t  sb[$];
  exp1_t sb1[$];
  exp_t  e;
  exp1_t e1;
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    last_acc  = -1000;
  int    last_acc1 = -1000;
  bit    rand_on;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitors: sample away from the active edge and compare against queued expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_acc = -1000;
    end else begin
      if (bus.out_valid) check("valid_ready_excl", bus.in_ready, 0);
      if (bus.in_valid && bus.in_ready) begin
        if (last_acc > -1000) check("accept_spacing", (cyc - last_acc) >= N + 2, 1);
        last_acc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("result_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sum", bus.out_sum, e.sum);
          check("cout", bus.out_cout, e.cout);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last_acc1 = -1000;
    end else begin
      if (bus1.out_valid) check("valid_ready_excl1", bus1.in_ready, 0);
      if (bus1.in_valid && bus1.in_ready) begin
        if (last_acc1 > -1000) check("accept_spacing1", (cyc - last_acc1) >= 3, 1);
        last_acc1 = cyc;
      end
      if (bus1.out_valid && bus1.out_ready) begin
        check("result_expected1", sb1.size() != 0, 1);
        if (sb1.size() != 0) begin
          e1 = sb1.pop_front();
          check("sum1", bus1.out_sum, e1.sum);
          check("cout1", bus1.out_cout, e1.cout);
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                      input logic [DW-1:0] es, input logic ec, input bit push);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("accept_timeout", bus.in_ready, 1);
    if (push) sb.push_back('{sum: es, cout: ec});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [W-1:0] es, input logic ec);
    int n = 0;
    bus1.in_valid = 1'b1;
    bus1.in_a     = a;
    bus1.in_b     = b;
    bus1.in_cin   = cin;
    while (!bus1.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("accept_timeout1", bus1.in_ready, 1);
    sb1.push_back('{sum: es, cout: ec});
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || sb1.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, sb.size() + sb1.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ones;
    logic [DW:0]   model;
    logic [W:0]    model1;
    logic [95:0]   r96;
    logic [DW-1:0] ra, rb;
    logic [W-1:0]  ra1, rb1;
    logic          rc;
    int            n;

    ones = '1;
    bus.in_valid  = 1'b0; bus.in_a  = '0; bus.in_b  = '0; bus.in_cin  = 1'b0; bus.out_ready  = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0; bus1.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum",   bus.out_sum, 0);
    check("rst_out_cout",  bus.out_cout, 0);
    check("rst_busy",      busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-width carry ripple with latency check
    send(ones, 88'd1, 1'b0, 88'd0, 1'b1, 1);
    repeat (N - 1) begin
      @(posedge clk); #1;
      check("latency_early", bus.out_valid, 0);
    end
    @(posedge clk); #1;
    check("latency_valid", bus.out_valid, 1);
    check("busy_done", busy, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_done", bus.in_ready, 1);

    // Directed carry cases
    send(88'h3FFFFF, 88'd1, 1'b0, 88'h400000, 1'b0, 1);
    send(88'd0, 88'd0, 1'b1, 88'd1, 1'b0, 1);
    send(ones, ones, 1'b1, ones, 1'b1, 1);
    send({4{22'h200000}}, {4{22'h200000}}, 1'b0, {22'h1, 22'h1, 22'h1, 22'h0}, 1'b1, 1);
    drain("drain_directed");

    // Backpressure held in DONE with a competing in_valid
    bus.out_ready = 1'b0;
    send(88'h12345, 88'h11111, 1'b0, 88'h23456, 1'b0, 1);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach_done", bus.out_valid, 1);
    bus.in_valid = 1'b1; bus.in_a = 88'd5; bus.in_b = 88'd6; bus.in_cin = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_sum_stable",  bus.out_sum, 88'h23456);
      check("bp_cout_stable", bus.out_cout, 0);
      check("bp_in_ready",    bus.in_ready, 0);
      check("bp_out_valid",   bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    check("bp_no_accept_yet", bus.in_ready, 0);
    @(posedge clk); #1;
    check("bp_accept_after_ready", bus.in_ready, 1);
    sb.push_back('{sum: 88'hC, cout: 1'b0});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain("drain_backpressure");

    // Reset in the second RUN cycle aborts silently
    send(88'd7, 88'd8, 1'b0, 88'd15, 1'b0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready",  bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_sum",   bus.out_sum, 0);
    check("abort_busy",      busy, 0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_result", bus.out_valid, 0);

    // Random back-to-back traffic with random out_ready
    rand_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          r96 = {$urandom(), $urandom(), $urandom()};
          ra  = (k % 17 == 0) ? ones : r96[DW-1:0];
          r96 = {$urandom(), $urandom(), $urandom()};
          rb  = r96[DW-1:0];
          rc  = 1'($urandom_range(0, 1));
          model = {1'b0, ra} + {1'b0, rb} + {{DW{1'b0}}, rc};
          send(ra, rb, rc, model[DW-1:0], model[DW], 1);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain("drain_random");

    // Single-chunk instance
    bus1.out_ready = 1'b0;
    send1(22'h3FFFFF, 22'h1, 1'b0, 22'h0, 1'b1);
    @(posedge clk); #1;
    check("n1_latency_valid", bus1.out_valid, 1);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    send1(22'h0, 22'h0, 1'b1, 22'h1, 1'b0);
    rand_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          ra1 = W'($urandom());
          rb1 = W'($urandom());
          rc  = 1'($urandom_range(0, 1));
          model1 = {1'b0, ra1} + {1'b0, rb1} + {{W{1'b0}}, rc};
          send1(ra1, rb1, rc, model1[W-1:0], model1[W]);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          bus1.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus1.out_ready = 1'b1;
    drain("drain_n1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
